bnn_fc_seq: RTL and testbench
=============================

Name: bnn_fc_seq

Overview:
- Sequential, parametrised binary fully-connected layer engine; successor to the hard-wired combinational BNN top.
- Weights, thresholds and signs are runtime-loadable per neuron through a config write port.
- Output neurons are time-multiplexed: PAR neurons are evaluated per cycle with XNOR-popcount plus threshold/sign.
- Instances are chained as hidden layers (binary activations out) or used as the classifier layer (raw scores out).

Parameters:
- N_IN, 64, input activation bits per vector.
- N_OUT, 16, output neurons; must be a multiple of PAR.
- PAR, 1, neurons evaluated per compute cycle.
- CW, $clog2(N_IN+1), score/threshold width (derived localparam, not overridable).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- cfg_we_i  in  1  write one neuron's parameters.
- cfg_addr_i  in  $clog2(N_OUT)  neuron index.
- cfg_wdata_i  in  N_IN  weight row.
- cfg_thr_i  in  CW  threshold.
- cfg_sign_i  in  2  activation mode.
- cfg_err_o  out  1  one-cycle pulse when a write is rejected.
- in_valid_i  in  1  input vector valid.
- in_ready_o  out  1  engine can accept a vector.
- layer_i  in  N_IN  binary input vector.
- out_valid_o  out  1  results valid.
- out_ready_i  in  1  consumer accepts results.
- act_o  out  N_OUT  binary activations.
- score_o  out  N_OUT*CW  raw popcount scores, neuron k at bits [k*CW +: CW].

Behaviour:
- Reset values: all weight, threshold and sign registers 0; state IDLE; act_o=0; score_o=0; out_valid_o=0; cfg_err_o=0; in_ready_o=1.
- Score and activation (neuron k):
  - score_k = popcount(~(layer ^ w_k)), range 0..N_IN, width CW, no overflow.
  - sign 2'b00: act = (score >= thr).
  - sign 2'b01: act = (score < thr).
  - sign 2'b10: act = 1.
  - sign 2'b11: act = 0.
- FSM states IDLE, COMP, DONE.
- IDLE:
  - in_ready_o=1.
  - On in_valid_i && in_ready_o: latch layer_i, clear neuron counter, go to COMP.
- COMP:
  - in_ready_o=0.
  - Each cycle evaluate neurons cnt*PAR .. cnt*PAR+PAR-1 and register their score/act into the output registers.
  - cnt increments each cycle.
  - After N_OUT/PAR cycles go to DONE.
- DONE:
  - out_valid_o=1; act_o/score_o stable.
  - On out_ready_i go to IDLE; out_valid_o drops the next cycle.
- Latency: N_OUT/PAR+1 cycles from input handshake to out_valid_o rising.
  - Throughput: one vector per N_OUT/PAR+2 cycles with out_ready_i tied to 1.
- Output registers keep their last results until overwritten during the next COMP.
- Config writes:
  - Accepted only in IDLE; update takes effect the next cycle.
  - A write in COMP or DONE is ignored and pulses cfg_err_o for one cycle.
  - cfg_addr_i >= N_OUT is ignored and pulses cfg_err_o.
- Simultaneous cfg_we_i and input handshake in IDLE: the write lands; the compute that starts uses the new row only if it has not yet been evaluated (always true, since evaluation starts the following cycle).
- in_valid_i in COMP/DONE: not accepted, no side effects; the upstream holds it.
- Reset mid-operation: immediate return to reset values, including all weights; an in-flight vector is discarded.

Optional Feature:
- Macro BNN_ARGMAX_EN.
- When defined:
  - Adds output port class_o, width $clog2(N_OUT): the index of the maximum score_k.
  - Computed as a running max during COMP; ties resolve to the lowest index.
  - Valid with out_valid_o; reset value 0.
- When undefined: port and logic are absent; behaviour is otherwise identical.

Test Plan (N_IN=16, N_OUT=4, PAR=1):
- Reset then idle:
  - Expect in_ready_o=1, out_valid_o=0, act_o=0, score_o=0.
- Single neuron, exact match:
  - Stimulus: neuron0 w=16'hA5A5, thr=8, sign=00; layer_i=16'hA5A5.
  - Expect score0=16, act0=1; out_valid_o rises 5 cycles after the handshake.
- Sign modes:
  - Neurons 0–3: w=16'h0000, thr=8, signs 00/01/10/11; layer_i=16'h00FF, so every score=8.
  - Expect act_o=4'b0101.
- Backpressure and blocking:
  - Hold out_ready_i=0 for 10 cycles after out_valid_o.
  - Expect outputs stable, in_ready_o=0, a second in_valid_i not accepted.
  - Release out_ready_i; the next vector is accepted in IDLE.
- Config rejection:
  - cfg_we_i in COMP, and cfg_addr_i=5 in IDLE.
  - Expect a cfg_err_o pulse each time and weights unchanged (readback via a recompute).
- Argmax (BNN_ARGMAX_EN) and async reset:
  - Argmax: scores {3,12,12,7}; expect class_o=1.
  - Async reset: assert rst_ni low mid-COMP; expect immediate out_valid_o=0 and IDLE state.

Source files
------------

// File: rtl/bnn_fc_seq.sv
// Sequential binary fully-connected layer: XNOR-popcount per neuron, PAR neurons per cycle.
// Optional BNN_ARGMAX_EN adds class_o, the lowest index of the maximum score.
module bnn_fc_seq #(
  parameter int N_IN  = 64,
  parameter int N_OUT = 16,
  parameter int PAR   = 1,
  localparam int CW   = $clog2(N_IN + 1),
  localparam int AW   = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cfg_we_i,
  input  logic [AW-1:0]         cfg_addr_i,
  input  logic [N_IN-1:0]       cfg_wdata_i,
  input  logic [CW-1:0]         cfg_thr_i,
  input  logic [1:0]            cfg_sign_i,
  output logic                  cfg_err_o,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [N_IN-1:0]       layer_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [N_OUT-1:0]      act_o,
  output logic [N_OUT*CW-1:0]   score_o
`ifdef BNN_ARGMAX_EN
  ,
  output logic [AW-1:0]         class_o
`endif
);

  localparam int NSTEP = N_OUT / PAR;
  localparam int CNTW  = (NSTEP > 1) ? $clog2(NSTEP) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, COMP = 2'd1, DONE = 2'd2} state_e;

  function automatic logic [CW-1:0] popcount_f(input logic [N_IN-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < N_IN; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  function automatic logic act_f(input logic [CW-1:0] sc, input logic [CW-1:0] thr,
                                 input logic [1:0] sg);
    case (sg)
      2'b00:   act_f = (sc >= thr);
      2'b01:   act_f = (sc < thr);
      2'b10:   act_f = 1'b1;
      2'b11:   act_f = 1'b0;
      default: act_f = 1'b0;
    endcase
  endfunction

  state_e                state_q, state_d;
  logic [N_IN-1:0]       layer_q, layer_d;
  logic [CNTW-1:0]       cnt_q, cnt_d;
  logic [N_OUT-1:0]      act_q, act_d;
  logic [N_OUT*CW-1:0]   score_q, score_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic                  cfg_err_q, cfg_err_d;
  logic                  cfg_ok_s;
  logic [CW-1:0]         sc_s;
  int                    idx_s;
  logic [N_IN-1:0]       w_q    [N_OUT];
  logic [CW-1:0]         thr_q  [N_OUT];
  logic [1:0]            sign_q [N_OUT];
`ifdef BNN_ARGMAX_EN
  logic [CW-1:0]         best_q, best_d;
  logic [AW-1:0]         class_q, class_d;
`endif

  // FSM next state, neuron evaluation and config acceptance
  always_comb begin
    state_d   = state_q;
    layer_d   = layer_q;
    cnt_d     = cnt_q;
    act_d     = act_q;
    score_d   = score_q;
    cfg_ok_s  = 1'b0;
    cfg_err_d = 1'b0;
    sc_s      = '0;
    idx_s     = 0;
`ifdef BNN_ARGMAX_EN
    best_d    = best_q;
    class_d   = class_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          layer_d = layer_i;
          cnt_d   = '0;
          state_d = COMP;
        end else begin
          state_d = IDLE;
        end
      end
      COMP: begin
`ifdef BNN_ARGMAX_EN
        // A new vector restarts the running max at neuron 0.
        if (cnt_q == '0) begin
          best_d  = '0;
          class_d = '0;
        end else begin
          best_d  = best_q;
          class_d = class_q;
        end
`endif
        for (int p = 0; p < PAR; p++) begin
          idx_s = int'(cnt_q) * PAR + p;
          sc_s  = popcount_f(~(layer_q ^ w_q[idx_s]));
          score_d[idx_s*CW +: CW] = sc_s;
          act_d[idx_s] = act_f(sc_s, thr_q[idx_s], sign_q[idx_s]);
`ifdef BNN_ARGMAX_EN
          if (sc_s > best_d || idx_s == 0) begin
            best_d  = sc_s;
            class_d = AW'(idx_s);
          end else begin
            best_d  = best_d;
          end
`endif
        end
        cnt_d = cnt_q + CNTW'(1);
        if (cnt_q == CNTW'(NSTEP - 1)) state_d = DONE;
        else                           state_d = COMP;
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
        else             state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    if (cfg_we_i) begin
      if (state_q == IDLE && int'(cfg_addr_i) < N_OUT) cfg_ok_s  = 1'b1;
      else                                             cfg_err_d = 1'b1;
    end else begin
      cfg_ok_s = 1'b0;
    end
  end

  assign in_ready_d  = (state_d == IDLE);
  assign out_valid_d = (state_d == DONE);

  // State, datapath and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      layer_q     <= '0;
      cnt_q       <= '0;
      act_q       <= '0;
      score_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
`ifdef BNN_ARGMAX_EN
      best_q      <= '0;
      class_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      layer_q     <= layer_d;
      cnt_q       <= cnt_d;
      act_q       <= act_d;
      score_q     <= score_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      cfg_err_q   <= cfg_err_d;
`ifdef BNN_ARGMAX_EN
      best_q      <= best_d;
      class_q     <= class_d;
`endif
    end
  end

  // Per-neuron parameter storage, written only from IDLE
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < N_OUT; k++) begin
        w_q[k]    <= '0;
        thr_q[k]  <= '0;
        sign_q[k] <= '0;
      end
    end else if (cfg_ok_s) begin
      w_q[cfg_addr_i]    <= cfg_wdata_i;
      thr_q[cfg_addr_i]  <= cfg_thr_i;
      sign_q[cfg_addr_i] <= cfg_sign_i;
    end
  end

  assign cfg_err_o   = cfg_err_q;
  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign act_o       = act_q;
  assign score_o     = score_q;
`ifdef BNN_ARGMAX_EN
  assign class_o     = class_q;
`endif

endmodule

// File: tb/tb_bnn_fc_seq.sv
// Directed bench for bnn_fc_seq (N_IN=16, N_OUT=4, PAR=1) plus an N_OUT=5 instance
// used for the out-of-range address check.
module tb_bnn_fc_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        cfg_we, cfg_err, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  cfg_addr, cfg_sign;
  logic [15:0] cfg_wdata, layer;
  logic [4:0]  cfg_thr;
  logic [3:0]  act;
  logic [19:0] score;
  logic        cfg_we5, cfg_err5, in_valid5, in_ready5, out_valid5;
  logic [2:0]  cfg_addr5;
  logic [4:0]  act5;
  logic [24:0] score5;
`ifdef BNN_ARGMAX_EN
  logic [1:0]  cls;
  logic [2:0]  cls5;
`endif

  int checks = 0;
  int errors = 0;
  int lat;

  bnn_fc_seq #(.N_IN(16), .N_OUT(4), .PAR(1)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr),
    .cfg_wdata_i(cfg_wdata), .cfg_thr_i(cfg_thr), .cfg_sign_i(cfg_sign), .cfg_err_o(cfg_err),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .layer_i(layer), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .act_o(act), .score_o(score)
`ifdef BNN_ARGMAX_EN
    , .class_o(cls)
`endif
  );

  bnn_fc_seq #(.N_IN(16), .N_OUT(5), .PAR(1)) u_dut5 (
    .clk_i(clk), .rst_ni(rst_n), .cfg_we_i(cfg_we5), .cfg_addr_i(cfg_addr5),
    .cfg_wdata_i(cfg_wdata), .cfg_thr_i(cfg_thr), .cfg_sign_i(cfg_sign), .cfg_err_o(cfg_err5),
    .in_valid_i(in_valid5), .in_ready_o(in_ready5), .layer_i(layer), .out_valid_o(out_valid5),
    .out_ready_i(1'b1), .act_o(act5), .score_o(score5)
`ifdef BNN_ARGMAX_EN
    , .class_o(cls5)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] pack4(input logic [4:0] s0, input logic [4:0] s1,
                                        input logic [4:0] s2, input logic [4:0] s3);
    return {s3, s2, s1, s0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [15:0] w, input logic [4:0] t,
                           input logic [1:0] s);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = w; cfg_thr = t; cfg_sign = s;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic cfg_write5(input logic [2:0] a, input logic [15:0] w, input logic [4:0] t,
                            input logic [1:0] s);
    cfg_we5 = 1'b1; cfg_addr5 = a; cfg_wdata = w; cfg_thr = t; cfg_sign = s;
    tick();
    cfg_we5 = 1'b0;
  endtask

  task automatic start_vec(input logic [15:0] l);
    int t;
    t = 0;
    while (!in_ready && t < 30) begin
      tick();
      t++;
    end
    layer = l;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Returns the index of the first out_valid cycle, handshake cycle being 0.
  task automatic wait_done(output int l);
    l = 1;
    while (!out_valid && l < 30) begin
      tick();
      l++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 16'h0000; cfg_thr = 5'd0;
    cfg_sign = 2'b00; in_valid = 1'b0; layer = 16'h0000; out_ready = 1'b0;
    cfg_we5 = 1'b0; cfg_addr5 = 3'd0; in_valid5 = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_act", act, 0);
    chk("rst_score", score, 0);
    chk("rst_cfg_err", cfg_err, 0);

    // Exact match on neuron 0; others have zero weights, thr 0
    cfg_write(2'd0, 16'hA5A5, 5'd8, 2'b00);
    chk("cfg_ok_no_err", cfg_err, 0);
    start_vec(16'hA5A5);
    wait_done(lat);
    chk("latency", lat, 5);
    chk("score0", score[4:0], 16);
    chk("act0", act[0], 1);
    chk("match_score", score, pack4(5'd16, 5'd8, 5'd8, 5'd8));
    chk("match_act", act, 4'hF);
    chk("done_in_ready", in_ready, 0);
    release_out();
    chk("rel_out_valid", out_valid, 0);
    chk("rel_in_ready", in_ready, 1);

    // Sign modes, every score 8
    cfg_write(2'd0, 16'h0000, 5'd8, 2'b00);
    cfg_write(2'd1, 16'h0000, 5'd8, 2'b01);
    cfg_write(2'd2, 16'h0000, 5'd8, 2'b10);
    cfg_write(2'd3, 16'h0000, 5'd8, 2'b11);
    start_vec(16'h00FF);
    wait_done(lat);
    chk("sign_act", act, 4'b0101);
    chk("sign_score", score, pack4(5'd8, 5'd8, 5'd8, 5'd8));

    // Backpressure with a competing vector held on the input
    layer = 16'hFFFF;
    in_valid = 1'b1;
    repeat (10) tick();
    chk("bp_out_valid", out_valid, 1);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_act_stable", act, 4'b0101);
    chk("bp_score_stable", score, pack4(5'd8, 5'd8, 5'd8, 5'd8));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_idle_ready", in_ready, 1);
    start_vec(16'hFFFF);
    wait_done(lat);
    chk("bp_next_latency", lat, 5);
    chk("bp_next_act", act, 4'b0110);
    chk("bp_next_score", score, 0);
    release_out();

    // Write during COMP is rejected
    start_vec(16'h00FF);
    cfg_write(2'd0, 16'h00FF, 5'd31, 2'b11);
    chk("comp_wr_err", cfg_err, 1);
    tick();
    chk("comp_wr_err_pulse", cfg_err, 0);
    wait_done(lat);
    chk("comp_wr_act", act, 4'b0101);
    release_out();
    start_vec(16'h00FF);
    wait_done(lat);
    chk("comp_wr_recompute_score", score, pack4(5'd8, 5'd8, 5'd8, 5'd8));
    chk("comp_wr_recompute_act", act, 4'b0101);
    release_out();

    // Out-of-range address on the N_OUT=5 instance
    cfg_write5(3'd5, 16'hFFFF, 5'd31, 2'b11);
    chk("addr5_err", cfg_err5, 1);
    tick();
    chk("addr5_err_pulse", cfg_err5, 0);
    cfg_write5(3'd4, 16'hFFFF, 5'd16, 2'b01);
    chk("addr4_no_err", cfg_err5, 0);
    layer = 16'hFFFF;
    in_valid5 = 1'b1;
    tick();
    in_valid5 = 1'b0;
    lat = 1;
    while (!out_valid5 && lat < 30) begin
      tick();
      lat++;
    end
    chk("dut5_done", out_valid5, 1);
    chk("dut5_act", act5, 5'b01111);
    chk("dut5_score", score5, 25'd16 << 20);

    // Scores {3,12,12,7}
    cfg_write(2'd0, 16'hFFF8, 5'd8, 2'b00);
    cfg_write(2'd1, 16'hF000, 5'd8, 2'b00);
    cfg_write(2'd2, 16'hF000, 5'd8, 2'b00);
    cfg_write(2'd3, 16'h01FF, 5'd8, 2'b00);
    start_vec(16'h0000);
    wait_done(lat);
    chk("amax_score", score, pack4(5'd3, 5'd12, 5'd12, 5'd7));
    chk("amax_act", act, 4'b0110);
`ifdef BNN_ARGMAX_EN
    chk("amax_class", cls, 1);
`endif
    release_out();

    // Asynchronous reset mid-COMP
    start_vec(16'h1234);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", in_ready, 1);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_act", act, 0);
    chk("arst_score", score, 0);
`ifdef BNN_ARGMAX_EN
    chk("arst_class", cls, 0);
`endif
    tick();
    rst_n = 1'b1;
    tick();
    start_vec(16'h0000);
    wait_done(lat);
    chk("arst_weights_cleared", score, pack4(5'd16, 5'd16, 5'd16, 5'd16));
    chk("arst_act_after", act, 4'hF);
    chk("arst_latency", lat, 5);
    release_out();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
